// File: rtl/sseg_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment display bus.
// A sample must hold steady before it is decoded; four distinct legal digits form a frame.
module sseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] hex,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err
);

  logic [10:0]     s1;
  logic [3:0]      cnt;
  logic [3:0][3:0] dreg;
  logic [3:0]      seen;

  logic [10:0]     raw;
  logic            stable, fire, onehot, legal;
  logic [3:0]      sel, new_seen;
  logic [1:0]      idx;
  logic [3:0]      nib;
  logic [3:0][3:0] nxt_d;

  always_comb begin
    raw    = {an, seg};
    stable = (raw == s1);
    // Fires only on the single edge where the count reaches saturation.
    fire   = stable && (cnt == 4'(STABLE_CYCLES - 1));
    sel    = ~s1[10:7];
    onehot = (sel != 4'b0) && ((sel & (sel - 4'd1)) == 4'b0);
    idx    = 2'd0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) idx = 2'(i);
    legal = 1'b1;
    nib   = 4'h0;
    case (s1[6:0])
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
    new_seen   = seen | (4'b0001 << idx);
    nxt_d      = dreg;
    nxt_d[idx] = nib;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= {4'b1111, 7'b1111111};
      cnt         <= 4'd0;
      dreg        <= '0;
      seen        <= 4'b0;
      hex         <= 16'h0000;
      digit_valid <= 4'b0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      s1          <= raw;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (!stable)
        cnt <= 4'd0;
      else if (cnt != 4'(STABLE_CYCLES))
        cnt <= cnt + 4'd1;
      if (fire && onehot) begin
        if (legal) begin
          dreg[idx]        <= nib;
          digit_valid[idx] <= 1'b1;
          if (new_seen == 4'b1111) begin
            hex         <= nxt_d;
            frame_valid <= 1'b1;
            seen        <= 4'b0;
          end else begin
            seen <= new_seen;
          end
        end else begin
          pattern_err      <= 1'b1;
          digit_valid[idx] <= 1'b0;
          seen             <= 4'b0;
        end
      end
    end
  end

endmodule
